// File: rtl/challenge_checker.sv
// Serial flag checker: compares one 7-bit character per enabled clock against EXPECTED.
// Define CHALLENGE_CHECKER_STATUS_EN to expose the count/fail status outputs.
module challenge_checker #(
   parameter int LEN = 49,
   // "pbctf{the_quick_brown_fox_jumps_over_lazy_dog_42}", 7 bits per char, char 0 in MSBs
   parameter logic [LEN*7-1:0] EXPECTED = {
      7'h70, 7'h62, 7'h63, 7'h74, 7'h66, 7'h7b,
      7'h74, 7'h68, 7'h65, 7'h5f,
      7'h71, 7'h75, 7'h69, 7'h63, 7'h6b, 7'h5f,
      7'h62, 7'h72, 7'h6f, 7'h77, 7'h6e, 7'h5f,
      7'h66, 7'h6f, 7'h78, 7'h5f,
      7'h6a, 7'h75, 7'h6d, 7'h70, 7'h73, 7'h5f,
      7'h6f, 7'h76, 7'h65, 7'h72, 7'h5f,
      7'h6c, 7'h61, 7'h7a, 7'h79, 7'h5f,
      7'h64, 7'h6f, 7'h67, 7'h5f,
      7'h34, 7'h32, 7'h7d}
) (
   input  logic                       clk,
   input  logic                       n_rst,
   input  logic                       en,
   input  logic [6:0]                 next_byte,
`ifdef CHALLENGE_CHECKER_STATUS_EN
   output logic [$clog2(LEN+1)-1:0]   count,
   output logic                       fail,
`endif
   output logic                       win
);

   localparam int IW = $clog2(LEN+1);
   localparam logic [IW-1:0] LEN_IDX = IW'(LEN);

   logic [IW-1:0] idx_q, idx_d;
   logic          bad_q, bad_d;
   logic          win_q, win_d;
   logic [6:0]    exp_char;

   // Character ROM; idx == LEN falls through to the unused default.
   always_comb begin
      exp_char = '0;
      for (int i = 0; i < LEN; i++) begin
         if (idx_q == IW'(i)) exp_char = EXPECTED[LEN*7-1-i*7 -: 7];
      end
   end

   always_comb begin
      idx_d = idx_q;
      bad_d = bad_q;
      if (en) begin
         if (idx_q < LEN_IDX) begin
            if (next_byte != exp_char) bad_d = 1'b1;
            idx_d = idx_q + 1'b1;
         end else begin
            bad_d = 1'b1;
         end
      end
      win_d = (idx_d == LEN_IDX) && !bad_d;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         idx_q <= '0;
         bad_q <= 1'b0;
         win_q <= 1'b0;
      end else begin
         idx_q <= idx_d;
         bad_q <= bad_d;
         win_q <= win_d;
      end
   end

   assign win = win_q;
`ifdef CHALLENGE_CHECKER_STATUS_EN
   assign count = idx_q;
   assign fail  = bad_q;
`endif

endmodule

// File: tb/tb_challenge_checker.sv
// Self-checking bench for challenge_checker: directed scenarios plus random streams vs a reference model.
module tb_challenge_checker;

   localparam int LEN = 49;
   localparam int IW  = $clog2(LEN+1);
   localparam string EXP_S = "pbctf{the_quick_brown_fox_jumps_over_lazy_dog_42}";

   logic          clk = 1'b0;
   logic          n_rst = 1'b0;
   logic          en = 1'b0;
   logic [6:0]    next_byte = '0;
   logic          win;
`ifdef CHALLENGE_CHECKER_STATUS_EN
   logic [IW-1:0] count;
   logic          fail;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: how many chars were accepted and whether all in-range ones matched.
   int m_acc = 0;
   bit m_ok  = 1'b1;

   challenge_checker dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .en        (en),
      .next_byte (next_byte),
`ifdef CHALLENGE_CHECKER_STATUS_EN
      .count     (count),
      .fail      (fail),
`endif
      .win       (win)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs(input string tag);
      int exp_cnt;
      exp_cnt = (m_acc > LEN) ? LEN : m_acc;
      chk({tag, ".win"}, 32'(win), 32'(m_ok && m_acc == LEN));
`ifdef CHALLENGE_CHECKER_STATUS_EN
      chk({tag, ".count"}, 32'(count), 32'(exp_cnt));
      chk({tag, ".fail"}, 32'(fail), 32'(!m_ok || m_acc > LEN));
`else
      if (exp_cnt < 0) $display("model count underflow");
`endif
   endtask

   function automatic logic [6:0] exp_char(input int i);
      byte c;
      c = EXP_S[i];
      return c[6:0];
   endfunction

   task automatic step(input logic e, input logic [6:0] b, input string tag);
      @(negedge clk);
      en = e;
      next_byte = b;
      @(posedge clk);
      if (e) begin
         if (m_acc < LEN && b != exp_char(m_acc)) m_ok = 1'b0;
         if (m_acc >= LEN) m_ok = 1'b0;
         m_acc++;
      end
      #1;
      check_outputs(tag);
   endtask

   task automatic send(input string s, input string tag);
      byte c;
      for (int i = 0; i < s.len(); i++) begin
         c = s[i];
         step(1'b1, c[6:0], tag);
      end
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) step(1'b0, 7'h00, tag);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 n_rst = 1'b0;
      en = 1'b0;
      m_acc = 0;
      m_ok  = 1'b1;
      #1 check_outputs("reset");
      @(negedge clk);
      n_rst = 1'b1;
   endtask

   initial begin
      string s;
      int    thr;
      logic  e;
      logic [6:0] b;

      repeat (3) @(posedge clk);
      #1 check_outputs("por");
      @(negedge clk);
      n_rst = 1'b1;

      send(EXP_S, "full");
      idle(10, "full_idle");

      do_reset();
      send("pbctf{AHOY_PEKO_PEKO_shaak_nanodesu}", "ahoy");
      idle(3, "ahoy_idle");

      do_reset();
      send(EXP_S.substr(0, LEN-2), "short");
      idle(5, "short_idle");
      step(1'b1, exp_char(LEN-1), "gap_last");
      idle(2, "gap_idle");

      do_reset();
      send(EXP_S, "over_body");
      step(1'b1, 7'h78, "over_x");
      idle(2, "over_idle");

      do_reset();
      s = EXP_S;
      s.putc(LEN-1, "{");
      send(s, "lastbad");
      idle(2, "lastbad_idle");

      do_reset();
      send(EXP_S.substr(0, 19), "mid");
      do_reset();
      send(EXP_S, "after_rst");
      idle(2, "after_rst_idle");

      for (int it = 0; it < 30; it++) begin
         do_reset();
         thr = ($urandom_range(0, 1) == 0) ? 0 : 3;
         for (int k = 0; k < 70; k++) begin
            e = ($urandom_range(0, 9) < 8);
            if (m_acc < LEN && $urandom_range(0, 99) >= thr)
               b = exp_char(m_acc);
            else
               b = 7'($urandom_range(0, 127));
            if (m_acc >= LEN + 2) e = 1'b0;
            step(e, b, "rand");
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
